// File: rtl/tx_pkt_pkg.sv
// Shared definitions for the segment packetizer: FSM state encoding,
// Ethernet framing lengths and the CRC-32 constants and byte step.
package tx_pkt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      HEADER,
      PAYLOAD,
      FCS,
      IFG
   } state_e;

   localparam int PREAMBLE_LEN = 8;
   localparam int ETH_HDR_LEN  = 18;
   localparam int FCS_LEN      = 4;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD           = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

   // One byte through the reflected CRC-32, LSB of the byte first.
   function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/tx_segment_packetizer_crc32_d8.sv
// Byte-wide combinational CRC-32 next-state; the running value is held
// in a register in the parent.
module crc32_d8
   import tx_pkt_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   // Advance the CRC by one byte.
   always_comb begin
      crc_o = crc32_step(crc_i, data_i);
   end

endmodule

// File: rtl/tx_segment_packetizer.sv
// Frames one buffered video segment as a raw Ethernet packet on a GMII
// byte bus and repeats it `redundancy` times, tagging each copy with
// txid, copy index and segment number.
// Optional feature macro: TXPKT_FCS_EN (CRC-32 engine and FCS state).
// Without it, frames end after the payload and a later MAC appends FCS.
module tx_segment_packetizer
   import tx_pkt_pkg::*;
#(
   parameter int          PAYLOAD_LEN = 1000,
   parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
   parameter logic [47:0] SRC_MAC     = 48'h000A35000001,
   parameter logic [15:0] ETHERTYPE   = 16'h88B5,
   parameter int          IFG_LEN     = 12
) (
   input  logic        clk125MHz,
   input  logic        rstn,
   input  logic        start,
   input  logic [7:0]  txid,
   input  logic [15:0] segment_num,
   input  logic [7:0]  redundancy,
   output logic [12:0] bram_addr,
   output logic        bram_en,
   input  logic [7:0]  bram_dout,
   output logic [7:0]  txd,
   output logic        txen,
   output logic        busy,
   output logic        done
);

   localparam logic [12:0] PRE_LAST = 13'(PREAMBLE_LEN - 1);
   localparam logic [12:0] HDR_LAST = 13'(ETH_HDR_LEN - 1);
   localparam logic [12:0] PAY_LAST = 13'(PAYLOAD_LEN - 1);
   localparam logic [12:0] IFG_LAST = 13'(IFG_LEN - 1);
`ifdef TXPKT_FCS_EN
   localparam logic [12:0] FCS_LAST = 13'(FCS_LEN - 1);
`endif

   state_e      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic [7:0]  copy_q, copy_d;
   logic [7:0]  ncopy_q, ncopy_d;
   logic [7:0]  txid_q, txid_d;
   logic [15:0] seg_q, seg_d;
   logic        done_q, done_d;
   logic [7:0]  hdr_byte;

`ifdef TXPKT_FCS_EN
   logic [31:0] crc_q;
   logic [31:0] crc_next;

   crc32_d8 u_crc (
      .crc_i  (crc_q),
      .data_i (txd),
      .crc_o  (crc_next)
   );

   // Running CRC: seeded during the preamble, folds in every header and payload byte.
   always_ff @(posedge clk125MHz or negedge rstn) begin
      if (!rstn) begin
         crc_q <= '0;
      end else if (state_q == PREAMBLE) begin
         crc_q <= CRC_INIT;
      end else if (state_q == HEADER || state_q == PAYLOAD) begin
         crc_q <= crc_next;
      end
   end
`endif

   // State register together with the byte/copy counters and latched transfer fields.
   always_ff @(posedge clk125MHz or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         copy_q  <= '0;
         ncopy_q <= '0;
         txid_q  <= '0;
         seg_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         copy_q  <= copy_d;
         ncopy_q <= ncopy_d;
         txid_q  <= txid_d;
         seg_q   <= seg_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: each framing phase lasts a fixed number of bytes, counted by cnt.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 13'd1;
      copy_d  = copy_q;
      ncopy_d = ncopy_q;
      txid_d  = txid_q;
      seg_d   = seg_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               txid_d  = txid;
               seg_d   = segment_num;
               ncopy_d = (redundancy == 8'd0) ? 8'd1 : redundancy;
               copy_d  = '0;
               state_d = PREAMBLE;
            end
         end
         PREAMBLE: begin
            if (cnt_q == PRE_LAST) begin
               cnt_d   = '0;
               state_d = HEADER;
            end
         end
         HEADER: begin
            if (cnt_q == HDR_LAST) begin
               cnt_d   = '0;
               state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (cnt_q == PAY_LAST) begin
               cnt_d   = '0;
`ifdef TXPKT_FCS_EN
               state_d = FCS;
`else
               state_d = IFG;
`endif
            end
         end
`ifdef TXPKT_FCS_EN
         FCS: begin
            if (cnt_q == FCS_LAST) begin
               cnt_d   = '0;
               state_d = IFG;
            end
         end
`endif
         IFG: begin
            if (cnt_q == IFG_LAST) begin
               cnt_d = '0;
               if (copy_q == ncopy_q - 8'd1) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  copy_d  = copy_q + 8'd1;
                  state_d = PREAMBLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Header byte selected by position: DST, SRC, ethertype, then the redundancy tag.
   always_comb begin
      hdr_byte = 8'h00;
      case (cnt_q)
         13'd0:   hdr_byte = DST_MAC[47:40];
         13'd1:   hdr_byte = DST_MAC[39:32];
         13'd2:   hdr_byte = DST_MAC[31:24];
         13'd3:   hdr_byte = DST_MAC[23:16];
         13'd4:   hdr_byte = DST_MAC[15:8];
         13'd5:   hdr_byte = DST_MAC[7:0];
         13'd6:   hdr_byte = SRC_MAC[47:40];
         13'd7:   hdr_byte = SRC_MAC[39:32];
         13'd8:   hdr_byte = SRC_MAC[31:24];
         13'd9:   hdr_byte = SRC_MAC[23:16];
         13'd10:  hdr_byte = SRC_MAC[15:8];
         13'd11:  hdr_byte = SRC_MAC[7:0];
         13'd12:  hdr_byte = ETHERTYPE[15:8];
         13'd13:  hdr_byte = ETHERTYPE[7:0];
         13'd14:  hdr_byte = txid_q;
         13'd15:  hdr_byte = copy_q;
         13'd16:  hdr_byte = seg_q[15:8];
         13'd17:  hdr_byte = seg_q[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   // Outputs decoded from state; BRAM is read one byte ahead so payload bytes arrive back to back.
   always_comb begin
      txd       = 8'h00;
      txen      = 1'b0;
      bram_en   = 1'b0;
      bram_addr = '0;
      busy      = (state_q != IDLE);
      done      = done_q;
      case (state_q)
         PREAMBLE: begin
            txen = 1'b1;
            txd  = (cnt_q == PRE_LAST) ? SFD : PREAMBLE_BYTE;
         end
         HEADER: begin
            txen    = 1'b1;
            txd     = hdr_byte;
            bram_en = (cnt_q == HDR_LAST);
         end
         PAYLOAD: begin
            txen = 1'b1;
            txd  = bram_dout;
            if (cnt_q < PAY_LAST) begin
               bram_en   = 1'b1;
               bram_addr = cnt_q + 13'd1;
            end
         end
`ifdef TXPKT_FCS_EN
         FCS: begin
            txen = 1'b1;
            case (cnt_q[1:0])
               2'd0:    txd = ~crc_q[7:0];
               2'd1:    txd = ~crc_q[15:8];
               2'd2:    txd = ~crc_q[23:16];
               default: txd = ~crc_q[31:24];
            endcase
         end
`endif
         default: begin
            txen = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_tx_segment_packetizer.sv
// Scoreboard bench for tx_segment_packetizer. Stimulus pushes the expected
// byte image of every frame; a GMII monitor collects frames and compares.
// Honours TXPKT_FCS_EN the same way as the design.
module tb_tx_segment_packetizer;

   localparam int P   = 1000;
   localparam int IFG = 12;

   logic        clk125MHz;
   logic        rstn;
   logic        start;
   logic [7:0]  txid;
   logic [15:0] segment_num;
   logic [7:0]  redundancy;
   logic [12:0] bram_addr;
   logic        bram_en;
   logic [7:0]  bram_dout;
   logic [7:0]  txd;
   logic        txen;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [7:0] expBytes[$];
   int         expLens[$];
   int         doneSeen     = 0;
   int         doneExpected = 0;

   logic [7:0] mem [0:8191];
   logic [7:0] got[$];
   bit         inFrame   = 0;
   bit         gapActive = 0;
   int         gapCnt    = 0;

   tx_segment_packetizer #(
      .PAYLOAD_LEN (P),
      .IFG_LEN     (IFG)
   ) dut (
      .clk125MHz   (clk125MHz),
      .rstn        (rstn),
      .start       (start),
      .txid        (txid),
      .segment_num (segment_num),
      .redundancy  (redundancy),
      .bram_addr   (bram_addr),
      .bram_en     (bram_en),
      .bram_dout   (bram_dout),
      .txd         (txd),
      .txen        (txen),
      .busy        (busy),
      .done        (done)
   );

   // 125 MHz clock
   initial begin
      clk125MHz = 1'b0;
      forever #4 clk125MHz = ~clk125MHz;
   end

   // BRAM image byte[i] = i[7:0]
   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = i[7:0];
   end

   // BRAM with one-cycle read latency
   always @(posedge clk125MHz) begin
      if (bram_en) bram_dout <= mem[bram_addr];
   end

   // Bit-serial reference CRC-32 (reflected), no final inversion
   function automatic logic [31:0] swCrc(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ b[i];
         r  = r >> 1;
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Build the full byte image of one copy and queue it
   task automatic pushFrame(input logic [7:0] id, input logic [7:0] copy, input logic [15:0] seg);
      logic [7:0]  f[$];
      logic [47:0] dst;
      logic [47:0] src;
      logic [31:0] c;
      dst = 48'hFFFFFFFFFFFF;
      src = 48'h000A35000001;
      for (int i = 0; i < 7; i++) f.push_back(8'h55);
      f.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) f.push_back(dst[8*i +: 8]);
      for (int i = 5; i >= 0; i--) f.push_back(src[8*i +: 8]);
      f.push_back(8'h88);
      f.push_back(8'hB5);
      f.push_back(id);
      f.push_back(copy);
      f.push_back(seg[15:8]);
      f.push_back(seg[7:0]);
      for (int k = 0; k < P; k++) f.push_back(k[7:0]);
`ifdef TXPKT_FCS_EN
      c = 32'hFFFFFFFF;
      for (int i = 8; i < f.size(); i++) c = swCrc(c, f[i]);
      c = ~c;
      f.push_back(c[7:0]);
      f.push_back(c[15:8]);
      f.push_back(c[23:16]);
      f.push_back(c[31:24]);
`endif
      expLens.push_back(f.size());
      foreach (f[i]) expBytes.push_back(f[i]);
   endtask

   // Called #1 after a rising edge with the DUT idle
   task automatic applyStimulus(input logic [7:0] id, input logic [15:0] seg,
                                input logic [7:0] red, input int pushCount, input bit expectDone);
      for (int c = 0; c < pushCount; c++) pushFrame(id, 8'(c), seg);
      if (expectDone) doneExpected++;
      txid        = id;
      segment_num = seg;
      redundancy  = red;
      start       = 1'b1;
      @(posedge clk125MHz);
      #1;
      start = 1'b0;
      checkOutput("latency_txen", {31'd0, txen}, 32'd1);
      checkOutput("latency_busy", {31'd0, busy}, 32'd1);
      checkOutput("first_preamble", {24'd0, txd}, 32'h55);
   endtask

   task automatic waitDone(input int budget);
      int b;
      b = budget;
      while (doneSeen < doneExpected && b > 0) begin
         @(posedge clk125MHz);
         b--;
      end
      repeat (2) @(posedge clk125MHz);
      #1;
      checkOutput("done_count", doneSeen, doneExpected);
      checkOutput("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   // GMII monitor: collects frames, measures gaps, counts done pulses
   always @(negedge clk125MHz) begin
      int          L;
      int          mism;
      int          firstBad;
      logic [7:0]  e;
      logic [31:0] c;
      if (!rstn) begin
         inFrame   = 0;
         gapActive = 0;
         gapCnt    = 0;
         got.delete();
      end else begin
         if (done) begin
            doneSeen++;
            if (gapActive) checkOutput("done_after_ifg", gapCnt, IFG);
            gapActive = 0;
         end
         if (txen) begin
            if (!inFrame) begin
               if (gapActive) checkOutput("ifg_gap", gapCnt, IFG);
               gapActive = 0;
               inFrame   = 1;
               got.delete();
            end
            got.push_back(txd);
         end else if (inFrame) begin
            inFrame = 0;
            checkOutput("frame_expected", {31'd0, expLens.size() > 0}, 32'd1);
            if (expLens.size() > 0) begin
               L        = expLens.pop_front();
               mism     = 0;
               firstBad = -1;
               for (int i = 0; i < L; i++) begin
                  e = expBytes.pop_front();
                  if (i < got.size() && got[i] !== e) begin
                     mism++;
                     if (firstBad < 0) firstBad = i;
                  end
               end
               checkOutput("frame_len", got.size(), L);
               checkOutput("frame_byte_errors", mism, 0);
               if (firstBad >= 0) $display("[TB] first differing byte at index %0d", firstBad);
`ifdef TXPKT_FCS_EN
               c = 32'hFFFFFFFF;
               for (int i = 8; i < got.size(); i++) c = swCrc(c, got[i]);
               checkOutput("fcs_residue", c, 32'hDEBB20E3);
`endif
            end
            gapActive = 1;
            gapCnt    = 1;
         end else if (gapActive) begin
            gapCnt++;
         end
      end
   end

   // Watchdog
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios
   initial begin
      rstn        = 1'b0;
      start       = 1'b0;
      txid        = '0;
      segment_num = '0;
      redundancy  = '0;
      repeat (3) @(posedge clk125MHz);
      #1;
      checkOutput("reset_txen", {31'd0, txen}, 32'd0);
      checkOutput("reset_txd", {24'd0, txd}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_bram_en", {31'd0, bram_en}, 32'd0);
      rstn = 1'b1;
      repeat (2) @(posedge clk125MHz);
      #1;

      $display("[TB] scenario 1: three copies");
      applyStimulus(8'h05, 16'h0102, 8'd3, 3, 1'b1);
      waitDone(5000);

      $display("[TB] scenario 2: redundancy 0 sends one copy");
      applyStimulus(8'h11, 16'hFFFE, 8'd0, 1, 1'b1);
      waitDone(2000);

      $display("[TB] scenario 3: start while busy is ignored");
      applyStimulus(8'h21, 16'h0A0B, 8'd2, 2, 1'b1);
      repeat (500) @(posedge clk125MHz);
      #1;
      txid        = 8'hAA;
      segment_num = 16'h5555;
      redundancy  = 8'd4;
      start       = 1'b1;
      @(posedge clk125MHz);
      #1;
      start = 1'b0;
      waitDone(4000);

      $display("[TB] scenario 4: inputs change while busy");
      applyStimulus(8'h33, 16'hBEEF, 8'd2, 2, 1'b1);
      txid        = 8'h77;
      segment_num = 16'h1234;
      redundancy  = 8'd5;
      waitDone(4000);

      $display("[TB] scenario 5: reset during payload of copy 1");
      applyStimulus(8'h44, 16'h0203, 8'd3, 1, 1'b0);
      repeat (1170) @(posedge clk125MHz);
      #1;
      checkOutput("txen_before_abort", {31'd0, txen}, 32'd1);
      rstn = 1'b0;
      #1;
      checkOutput("abort_txen", {31'd0, txen}, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk125MHz);
      #1;
      rstn = 1'b1;
      repeat (2) @(posedge clk125MHz);
      #1;
      checkOutput("abort_no_done", doneSeen, doneExpected);
      applyStimulus(8'h55, 16'h0304, 8'd1, 1, 1'b1);
      waitDone(2000);

      repeat (20) @(posedge clk125MHz);
      #1;
      checkOutput("leftover_frames", expLens.size(), 0);
      checkOutput("done_total", doneSeen, doneExpected);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
